atm_session_controller: RTL and testbench



---
 rtl/atm_session_controller.sv | 234 +++++++++++++++++++++++
 tb/tb_atm_session_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_controller.sv
`default_nettype none
// ============================================================================
// Module  : atm_session_controller
// Brief   : Session FSM feeding the ATM datapath (one-hot state, ready strobes,
//           PIN lockout, message hold). Optional: ATM_INACTIVITY_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
module atm_session_controller #(
    parameter int MAX_PIN_TRIES  = 3,
    parameter int MSG_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_enter,
    input  logic        btn_back,
    input  logic [1:0]  menuOption,
    input  logic [3:0]  status_code,
    output logic [15:0] current_state,
    output logic        ready,
    output logic        busy,
    output logic        authenticated,
    output logic        locked_out
);

    typedef enum logic [3:0] {
        S_IDLE                      = 4'd0,
        S_ACC_NUM                   = 4'd1,
        S_PIN_INPUT                 = 4'd2,
        S_MENU                      = 4'd3,
        S_SHOW_BALANCES             = 4'd4,
        S_CONVERT_CURRENCY          = 4'd5,
        S_SELECT_CURRENCY_CONVERT_1 = 4'd6,
        S_SELECT_CURRENCY_CONVERT_2 = 4'd7,
        S_WITHDRAW                  = 4'd8,
        S_SELECT_AMOUNT_WITHDRAW    = 4'd9,
        S_TRANSFER                  = 4'd10,
        S_SELECT_CURRENCY_TRANSFER  = 4'd11,
        S_SELECT_AMOUNT_TRANSFER    = 4'd12,
        S_ERROR                     = 4'd13,
        S_SUCCESS                   = 4'd14
    } state_t;

    localparam logic [3:0] c_ACC_FOUND     = 4'd1;
    localparam logic [3:0] c_PIN_CORRECT   = 4'd3;
    localparam logic [3:0] c_PIN_INCORRECT = 4'd4;
    localparam logic [3:0] c_AMT_VALID     = 4'd5;
    localparam logic [7:0] c_MAX_TRIES     = 8'(MAX_PIN_TRIES);
    localparam logic [7:0] c_HOLD_LAST     = 8'(MSG_CYCLES - 1);

    logic       r_enter_d, r_back_d, r_enter_e, r_back_e;
    logic       w_enter, w_back;

    state_t     r_state, w_next_state, w_exit_target, w_back_target;
    logic       r_busy, r_ready, r_auth, r_locked;
    logic       w_next_busy, w_next_ready, w_next_auth, w_next_locked;
    logic [7:0] r_tries, w_next_tries, w_tries_inc;
    logic [7:0] r_hold;

    // The delayed copies track the buttons during reset so a held button
    // cannot fake a rising edge when reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enter_d <= btn_enter;
            r_back_d  <= btn_back;
            r_enter_e <= 1'b0;
            r_back_e  <= 1'b0;
        end else begin
            r_enter_d <= btn_enter;
            r_back_d  <= btn_back;
            r_enter_e <= btn_enter & ~r_enter_d;
            r_back_e  <= btn_back & ~r_back_d;
        end
    end

    assign w_enter = r_enter_e & ~r_back_e;
    assign w_back  = r_back_e;

`ifdef ATM_INACTIVITY_TIMEOUT_EN
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_idle_cnt;
    logic        w_timeout;

    assign w_timeout = !r_busy && (r_state != S_IDLE) && !(r_enter_e || r_back_e)
                       && (r_idle_cnt == c_TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset || r_state == S_IDLE || w_next_state != r_state || r_enter_e || r_back_e) begin
            r_idle_cnt <= 32'd0;
        end else if (!r_busy) begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        w_next_state  = r_state;
        w_next_busy   = r_busy;
        w_next_ready  = 1'b0;
        w_next_auth   = r_auth;
        w_next_locked = r_locked;
        w_next_tries  = r_tries;
        w_tries_inc   = r_tries + 8'd1;
        w_exit_target = (r_auth && !r_locked) ? S_MENU : S_IDLE;
        w_back_target = r_auth ? S_MENU : S_IDLE;

        if (r_busy) begin
            // First busy cycle carries the strobe; the second is the response slot.
            if (!r_ready) begin
                w_next_busy = 1'b0;
                case (r_state)
                    S_ACC_NUM:
                        w_next_state = (status_code == c_ACC_FOUND) ? S_PIN_INPUT : S_ERROR;
                    S_PIN_INPUT: begin
                        if (status_code == c_PIN_CORRECT) begin
                            w_next_state = S_MENU;
                            w_next_auth  = 1'b1;
                            w_next_tries = 8'd0;
                        end else if (status_code == c_PIN_INCORRECT) begin
                            w_next_tries = w_tries_inc;
                            if (w_tries_inc >= c_MAX_TRIES) begin
                                w_next_state  = S_ERROR;
                                w_next_locked = 1'b1;
                            end
                        end else begin
                            w_next_state = S_ERROR;
                        end
                    end
                    S_SELECT_CURRENCY_CONVERT_1:
                        w_next_state = (status_code == c_AMT_VALID) ? S_SELECT_CURRENCY_CONVERT_2 : S_ERROR;
                    S_SELECT_CURRENCY_CONVERT_2:
                        w_next_state = S_SUCCESS;
                    S_SELECT_AMOUNT_WITHDRAW, S_SELECT_AMOUNT_TRANSFER:
                        w_next_state = (status_code == c_AMT_VALID) ? S_SUCCESS : S_ERROR;
                    S_TRANSFER:
                        w_next_state = (status_code == c_ACC_FOUND) ? S_SELECT_CURRENCY_TRANSFER : S_ERROR;
                    default:
                        w_next_state = S_ERROR;
                endcase
            end
        end else if (w_back && !(r_state inside {S_IDLE, S_MENU, S_ERROR, S_SUCCESS})) begin
            w_next_state = w_back_target;
        end else begin
            case (r_state)
                S_IDLE:
                    if (w_enter) w_next_state = S_ACC_NUM;
                S_MENU: begin
                    if (w_back) begin
                        w_next_state = S_IDLE;
                    end else if (w_enter) begin
                        case (menuOption)
                            2'b00:   w_next_state = S_SHOW_BALANCES;
                            2'b01:   w_next_state = S_CONVERT_CURRENCY;
                            2'b10:   w_next_state = S_WITHDRAW;
                            default: w_next_state = S_TRANSFER;
                        endcase
                    end
                end
                S_SHOW_BALANCES:
                    if (w_enter) w_next_state = S_MENU;
                S_CONVERT_CURRENCY:
                    if (w_enter) w_next_state = S_SELECT_CURRENCY_CONVERT_1;
                S_WITHDRAW:
                    if (w_enter) w_next_state = S_SELECT_AMOUNT_WITHDRAW;
                S_SELECT_CURRENCY_TRANSFER:
                    if (w_enter) w_next_state = S_SELECT_AMOUNT_TRANSFER;
                S_ERROR, S_SUCCESS:
                    if (w_enter || r_hold == c_HOLD_LAST) w_next_state = w_exit_target;
                S_ACC_NUM, S_PIN_INPUT, S_SELECT_CURRENCY_CONVERT_1, S_SELECT_CURRENCY_CONVERT_2,
                S_SELECT_AMOUNT_WITHDRAW, S_TRANSFER, S_SELECT_AMOUNT_TRANSFER: begin
                    if (w_enter) begin
                        w_next_busy  = 1'b1;
                        w_next_ready = 1'b1;
                    end
                end
                default:
                    w_next_state = S_IDLE;
            endcase
        end

`ifdef ATM_INACTIVITY_TIMEOUT_EN
        if (w_timeout) begin
            w_next_state = S_IDLE;
            w_next_busy  = 1'b0;
            w_next_ready = 1'b0;
        end
`endif

        if (w_next_state == S_IDLE) begin
            w_next_auth   = 1'b0;
            w_next_locked = 1'b0;
            w_next_tries  = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_auth   <= 1'b0;
            r_locked <= 1'b0;
            r_tries  <= 8'd0;
        end else begin
            r_state  <= w_next_state;
            r_busy   <= w_next_busy;
            r_ready  <= w_next_ready;
            r_auth   <= w_next_auth;
            r_locked <= w_next_locked;
            r_tries  <= w_next_tries;
        end
    end

    // Message hold restarts on every state change, so it reads 0 on entry.
    always_ff @(posedge clk) begin
        if (reset || w_next_state != r_state) begin
            r_hold <= 8'd0;
        end else if (r_state == S_ERROR || r_state == S_SUCCESS) begin
            r_hold <= r_hold + 8'd1;
        end
    end

    always_comb begin
        current_state          = 16'h0000;
        current_state[r_state] = 1'b1;
    end

    assign ready         = r_ready;
    assign busy          = r_busy;
    assign authenticated = r_auth;
    assign locked_out    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_atm_session_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_atm_session_controller
// Brief   : Table-driven, scoreboarded bench for atm_session_controller.
// Rev     : 1.0
// ============================================================================
module tb_atm_session_controller;

    logic        clk;
    logic        reset;
    logic        btn_enter;
    logic        btn_back;
    logic [1:0]  menuOption;
    logic [3:0]  status_code;
    logic [15:0] current_state;
    logic        ready;
    logic        busy;
    logic        authenticated;
    logic        locked_out;

    atm_session_controller #(
        .MAX_PIN_TRIES (3),
        .MSG_CYCLES    (4),
        .TIMEOUT_CYCLES(20)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .btn_enter    (btn_enter),
        .btn_back     (btn_back),
        .menuOption   (menuOption),
        .status_code  (status_code),
        .current_state(current_state),
        .ready        (ready),
        .busy         (busy),
        .authenticated(authenticated),
        .locked_out   (locked_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {ready, busy, authenticated, locked_out}
    typedef struct {
        logic        rst;
        logic        en;
        logic        bk;
        logic [1:0]  menu;
        logic [3:0]  st;
        logic [15:0] xs;
        logic [3:0]  xf;
    } vec_t;

    typedef struct {
        logic [15:0] xs;
        logic [3:0]  xf;
        string       nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic e, input logic b, input logic [1:0] m,
                       input logic [3:0] s, input logic [15:0] xs, input logic [3:0] xf);
        vec_t v;
        v.rst = r; v.en = e; v.bk = b; v.menu = m; v.st = s; v.xs = xs; v.xf = xf;
        tbl.push_back(v);
    endtask

    task automatic check();
        exp_t       x;
        logic [3:0] af;
        x  = sb.pop_front();
        af = {ready, busy, authenticated, locked_out};
        n_vec++;
        if (current_state !== x.xs || af !== x.xf) begin
            n_bad++;
            $display("FAIL %s: got state=%h flags(rdy,bsy,auth,lock)=%b, expected state=%h flags=%b",
                     x.nm, current_state, af, x.xs, x.xf);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic b, input logic [1:0] m,
                        input logic [3:0] s, input logic [15:0] xs, input logic [3:0] xf,
                        input string nm);
        exp_t x;
        x.xs = xs; x.xf = xf; x.nm = nm;
        sb.push_back(x);
        reset = r; btn_enter = e; btn_back = b; menuOption = m; status_code = s;
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic login();
        step(0, 1, 0, 0, 0, 16'h0001, 4'b0000, "login_en1");
        step(0, 0, 0, 0, 0, 16'h0002, 4'b0000, "login_acc");
        step(0, 1, 0, 0, 0, 16'h0002, 4'b0000, "login_en2");
        step(0, 0, 0, 0, 0, 16'h0002, 4'b1100, "login_rdy1");
        step(0, 0, 0, 0, 1, 16'h0002, 4'b0100, "login_slot1");
        step(0, 0, 0, 0, 1, 16'h0004, 4'b0000, "login_pin");
        step(0, 1, 0, 0, 1, 16'h0004, 4'b0000, "login_en3");
        step(0, 0, 0, 0, 1, 16'h0004, 4'b1100, "login_rdy2");
        step(0, 0, 0, 0, 3, 16'h0004, 4'b0100, "login_slot2");
        step(0, 0, 0, 0, 3, 16'h0008, 4'b0010, "login_menu");
    endtask

    initial begin
        reset = 1'b1; btn_enter = 1'b0; btn_back = 1'b0; menuOption = 2'b00; status_code = 4'd0;
        @(posedge clk);
        #1;

        // Reset, login, show balances
        add(1,0,0,0,0,16'h0001,4'b0000);
        add(0,1,0,0,0,16'h0001,4'b0000);
        add(0,0,0,0,0,16'h0002,4'b0000);
        add(0,1,0,0,0,16'h0002,4'b0000);
        add(0,0,0,0,0,16'h0002,4'b1100);
        add(0,0,0,0,1,16'h0002,4'b0100);
        add(0,0,0,0,1,16'h0004,4'b0000);
        add(0,1,0,0,1,16'h0004,4'b0000);
        add(0,0,0,0,1,16'h0004,4'b1100);
        add(0,0,0,0,3,16'h0004,4'b0100);
        add(0,0,0,0,3,16'h0008,4'b0010);
        add(0,1,0,0,3,16'h0008,4'b0010);
        add(0,0,0,0,3,16'h0010,4'b0010);
        add(0,0,1,0,3,16'h0010,4'b0010);
        add(0,0,0,0,3,16'h0008,4'b0010);
        // Withdraw, AMT_VALID -> SUCCESS held 4 cycles
        add(0,1,0,2,3,16'h0008,4'b0010);
        add(0,0,0,2,3,16'h0100,4'b0010);
        add(0,1,0,2,3,16'h0100,4'b0010);
        add(0,0,0,2,3,16'h0200,4'b0010);
        add(0,1,0,2,0,16'h0200,4'b0010);
        add(0,0,0,2,0,16'h0200,4'b1110);
        add(0,0,0,2,5,16'h0200,4'b0110);
        for (int i = 0; i < 4; i++) add(0,0,0,2,5,16'h4000,4'b0010);
        add(0,0,0,2,5,16'h0008,4'b0010);
        // Withdraw, AMT_INVALID -> ERROR held 4 cycles
        add(0,1,0,2,5,16'h0008,4'b0010);
        add(0,0,0,2,5,16'h0100,4'b0010);
        add(0,1,0,2,5,16'h0100,4'b0010);
        add(0,0,0,2,5,16'h0200,4'b0010);
        add(0,1,0,2,5,16'h0200,4'b0010);
        add(0,0,0,2,5,16'h0200,4'b1110);
        add(0,0,0,2,6,16'h0200,4'b0110);
        for (int i = 0; i < 4; i++) add(0,0,0,2,6,16'h2000,4'b0010);
        add(0,0,0,2,6,16'h0008,4'b0010);
        // Transfer: stale status 5 outside slot, buttons while busy ignored
        add(0,1,0,3,5,16'h0008,4'b0010);
        add(0,0,0,3,5,16'h0400,4'b0010);
        add(0,1,0,3,5,16'h0400,4'b0010);
        add(0,0,1,3,5,16'h0400,4'b1110);
        add(0,1,0,3,5,16'h0400,4'b0110);
        add(0,0,0,3,2,16'h2000,4'b0010);
        for (int i = 0; i < 3; i++) add(0,0,0,3,5,16'h2000,4'b0010);
        add(0,0,0,3,5,16'h0008,4'b0010);
        // Convert currency, SUCCESS left early by enter
        add(0,1,0,1,5,16'h0008,4'b0010);
        add(0,0,0,1,5,16'h0020,4'b0010);
        add(0,1,0,1,5,16'h0020,4'b0010);
        add(0,0,0,1,5,16'h0040,4'b0010);
        add(0,1,0,1,5,16'h0040,4'b0010);
        add(0,0,0,1,5,16'h0040,4'b1110);
        add(0,0,0,1,5,16'h0040,4'b0110);
        add(0,0,0,1,5,16'h0080,4'b0010);
        add(0,1,0,1,0,16'h0080,4'b0010);
        add(0,0,0,1,0,16'h0080,4'b1110);
        add(0,0,0,1,0,16'h0080,4'b0110);
        add(0,0,0,1,0,16'h4000,4'b0010);
        add(0,1,0,1,0,16'h4000,4'b0010);
        add(0,0,0,1,0,16'h0008,4'b0010);
        // Transfer to SELECT_CURRENCY_TRANSFER, enter+back together -> MENU
        add(0,1,0,3,0,16'h0008,4'b0010);
        add(0,0,0,3,0,16'h0400,4'b0010);
        add(0,1,0,3,0,16'h0400,4'b0010);
        add(0,0,0,3,0,16'h0400,4'b1110);
        add(0,0,0,3,1,16'h0400,4'b0110);
        add(0,0,0,3,1,16'h0800,4'b0010);
        add(0,1,1,3,1,16'h0800,4'b0010);
        add(0,0,0,3,1,16'h0008,4'b0010);
        // Logout, then PIN lockout after three PIN_INCORRECT
        add(0,0,1,0,0,16'h0008,4'b0010);
        add(0,0,0,0,0,16'h0001,4'b0000);
        add(0,1,0,0,0,16'h0001,4'b0000);
        add(0,0,0,0,0,16'h0002,4'b0000);
        add(0,1,0,0,0,16'h0002,4'b0000);
        add(0,0,0,0,0,16'h0002,4'b1100);
        add(0,0,0,0,1,16'h0002,4'b0100);
        add(0,0,0,0,1,16'h0004,4'b0000);
        for (int t = 0; t < 3; t++) begin
            add(0,1,0,0,4,16'h0004,4'b0000);
            add(0,0,0,0,4,16'h0004,4'b1100);
            add(0,0,0,0,4,16'h0004,4'b0100);
            add(0,0,0,0,4,(t == 2) ? 16'h2000 : 16'h0004,(t == 2) ? 4'b0001 : 4'b0000);
        end
        for (int i = 0; i < 3; i++) add(0,0,0,0,4,16'h2000,4'b0001);
        add(0,0,0,0,4,16'h0001,4'b0000);
        // Back before authentication -> IDLE
        add(0,1,0,0,0,16'h0001,4'b0000);
        add(0,0,0,0,0,16'h0002,4'b0000);
        add(0,0,1,0,0,16'h0002,4'b0000);
        add(0,0,0,0,0,16'h0001,4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].bk, tbl[i].menu, tbl[i].st,
                 tbl[i].xs, tbl[i].xf, $sformatf("vec%0d", i));
        end

        // Button held through reset produces no edge
        step(1, 1, 0, 0, 0, 16'h0001, 4'b0000, "held_rst");
        step(0, 1, 0, 0, 0, 16'h0001, 4'b0000, "held_rel1");
        step(0, 1, 0, 0, 0, 16'h0001, 4'b0000, "held_rel2");
        step(0, 0, 0, 0, 0, 16'h0001, 4'b0000, "held_rel3");

        // Reset asserted while ready=1 drops the request
        step(0, 1, 0, 0, 0, 16'h0001, 4'b0000, "rmid_en1");
        step(0, 0, 0, 0, 0, 16'h0002, 4'b0000, "rmid_acc");
        step(0, 1, 0, 0, 0, 16'h0002, 4'b0000, "rmid_en2");
        step(0, 0, 0, 0, 0, 16'h0002, 4'b1100, "rmid_rdy");
        step(1, 0, 0, 0, 1, 16'h0001, 4'b0000, "rmid_rst");
        step(0, 0, 0, 0, 1, 16'h0001, 4'b0000, "rmid_after1");
        step(0, 0, 0, 0, 1, 16'h0001, 4'b0000, "rmid_after2");

        // Inactivity in MENU
        login();
        for (int i = 0; i < 100; i++) begin
`ifdef ATM_INACTIVITY_TIMEOUT_EN
            step(0, 0, 0, 0, 0, (i >= 19) ? 16'h0001 : 16'h0008, (i >= 19) ? 4'b0000 : 4'b0010,
                 $sformatf("idle%0d", i));
`else
            step(0, 0, 0, 0, 0, 16'h0008, 4'b0010, $sformatf("idle%0d", i));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
